paddle_move_ctrl: RTL and testbench

//  Sequences paddle motion from decoded PS/2 key events (valid/makeBreak/outCode from keyboard_press_driver).

---
 rtl/paddle_move_ctrl.sv | 160 ++++++++++++++++
 tb/tb_paddle_move_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_move_ctrl.sv
// Paddle motion sequencer: tracks held left/right/launch keys, steps paddle_x at a divided rate with clamping, pulses launch.
// Optional build macro PADDLE_ACCEL_EN doubles the step size after 8 consecutive same-direction steps.
module paddle_move_ctrl #(
    parameter int          SCREEN_W    = 640,
    parameter int          PADDLE_W    = 80,
    parameter int          POS_W       = 10,
    parameter int          STEP        = 4,
    parameter int          MOVE_DIV    = 250000,
    parameter logic [7:0]  LEFT_CODE   = 8'h61,
    parameter logic [7:0]  RIGHT_CODE  = 8'h6A,
    parameter logic [7:0]  LAUNCH_CODE = 8'h29
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             makeBreak,
    input  logic [7:0]       outCode,
    input  logic             enable,
    output logic [POS_W-1:0] paddle_x,
    output logic             move_l,
    output logic             move_r,
    output logic             launch,
    output logic             at_edge
);

    localparam int               TICK_W     = $clog2(MOVE_DIV);
    localparam logic [TICK_W-1:0] L_TICK_MAX = TICK_W'(MOVE_DIV - 1);
    localparam logic [POS_W:0]   L_MAX_X    = (POS_W+1)'(SCREEN_W - PADDLE_W);
    localparam logic [POS_W-1:0] L_HOME     = POS_W'((SCREEN_W - PADDLE_W) / 2);
    localparam logic [POS_W:0]   L_STEP     = (POS_W+1)'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } dir_state_t;

    dir_state_t        r_state;
    dir_state_t        w_state_nxt;
    logic              r_held_l;
    logic              r_held_r;
    logic              r_held_s;
    logic              r_launch;
    logic [TICK_W-1:0] r_tick;
    logic [POS_W-1:0]  r_x;
    logic [POS_W-1:0]  w_x_nxt;
    logic [POS_W:0]    w_x_ext;
    logic [POS_W:0]    w_x_inc;
    logic [POS_W:0]    w_step_sz;
    logic              w_ev_l;
    logic              w_ev_r;
    logic              w_ev_s;
    logic              w_dir_chg;
    logic              w_step;

    // valid is a one-cycle event strobe with no back-pressure: every strobed event is consumed that cycle.
    assign w_ev_l = valid && (outCode == LEFT_CODE);
    assign w_ev_r = valid && (outCode == RIGHT_CODE);
    assign w_ev_s = valid && (outCode == LAUNCH_CODE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ev_l && makeBreak)
                    w_state_nxt = ST_LEFT;
                else if (w_ev_r && makeBreak)
                    w_state_nxt = ST_RIGHT;
            end
            ST_LEFT: begin
                if (w_ev_r && makeBreak)
                    w_state_nxt = ST_RIGHT;
                else if (w_ev_l && !makeBreak)
                    w_state_nxt = r_held_r ? ST_RIGHT : ST_IDLE;
            end
            ST_RIGHT: begin
                if (w_ev_l && makeBreak)
                    w_state_nxt = ST_LEFT;
                else if (w_ev_r && !makeBreak)
                    w_state_nxt = r_held_l ? ST_LEFT : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_dir_chg = (w_state_nxt != r_state);
    assign w_step    = (r_state != ST_IDLE) && enable && (r_tick == L_TICK_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_held_l <= 1'b0;
            r_held_r <= 1'b0;
            r_held_s <= 1'b0;
            r_launch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_launch <= w_ev_s && makeBreak && !r_held_s && enable;
            if (w_ev_l)
                r_held_l <= makeBreak;
            if (w_ev_r)
                r_held_r <= makeBreak;
            if (w_ev_s)
                r_held_s <= makeBreak;
        end
    end

    // Reloading on a direction change makes the first step in the new direction immediate.
    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_IDLE) || !enable || w_dir_chg)
            r_tick <= L_TICK_MAX;
        else if (r_tick == L_TICK_MAX)
            r_tick <= '0;
        else
            r_tick <= r_tick + 1'b1;
    end

`ifdef PADDLE_ACCEL_EN
    logic [3:0] r_step_cnt;

    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_IDLE) || !enable || w_dir_chg)
            r_step_cnt <= 4'd0;
        else if (w_step && (r_step_cnt != 4'd8))
            r_step_cnt <= r_step_cnt + 4'd1;
    end

    assign w_step_sz = (r_step_cnt == 4'd8) ? (L_STEP << 1) : L_STEP;
`else
    assign w_step_sz = L_STEP;
`endif

    // Clamp in POS_W+1 bits so neither wall can wrap.
    assign w_x_ext = {1'b0, r_x};
    assign w_x_inc = w_x_ext + w_step_sz;

    always_comb begin
        w_x_nxt = r_x;
        if (w_step) begin
            if (r_state == ST_LEFT)
                w_x_nxt = (w_x_ext < w_step_sz) ? '0 : (r_x - w_step_sz[POS_W-1:0]);
            else
                w_x_nxt = (w_x_inc > L_MAX_X) ? L_MAX_X[POS_W-1:0] : w_x_inc[POS_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_x <= L_HOME;
        else
            r_x <= w_x_nxt;
    end

    assign paddle_x = r_x;
    assign move_l   = (r_state == ST_LEFT);
    assign move_r   = (r_state == ST_RIGHT);
    assign launch   = r_launch;
    assign at_edge  = (r_x == '0) || (w_x_ext == L_MAX_X);

endmodule

// File: tb/tb_paddle_move_ctrl.sv
// Bench for paddle_move_ctrl (MOVE_DIV=4): directed key sequences, scoreboard queues checked by a negedge monitor.
module tb_paddle_move_ctrl;

  localparam int MAX_X = 560;
`ifdef PADDLE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  // clock/reset and DUT signals
  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       valid     = 1'b0;
  logic       makeBreak = 1'b0;
  logic [7:0] outCode   = 8'h00;
  logic       enable    = 1'b0;
  logic [9:0] paddle_x;
  logic       move_l;
  logic       move_r;
  logic       launch;
  logic       at_edge;

  int checks     = 0;
  int passes     = 0;
  int cyc        = 0;
  int launch_cnt = 0;
  int ev         = 0;
  bit mon_en     = 1'b0;

  logic [9:0] exp_x_q[$];
  logic [1:0] exp_dir_q[$];
  int         exp_launch_q[$];

  logic [9:0] prev_x   = 10'd280;
  logic [1:0] prev_dir = 2'b00;

  paddle_move_ctrl #(.MOVE_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .makeBreak (makeBreak),
    .outCode   (outCode),
    .enable    (enable),
    .paddle_x  (paddle_x),
    .move_l    (move_l),
    .move_r    (move_r),
    .launch    (launch),
    .at_edge   (at_edge)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic unexpected(input string name, input int act);
    checks++;
    $display("FAIL %s: got %0d expected no change", name, act);
  endtask

  // driver tasks
  task automatic key(input bit mk, input logic [7:0] code);
    valid = 1'b1;
    makeBreak = mk;
    outCode = code;
    @(posedge clk);
    #1;
    valid = 1'b0;
    ev = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // model of a held direction: clamped steps until the wall stops motion
  task automatic push_run(input int start, input int dir);
    int x;
    int n;
    int sz;
    int nx;
    x = start;
    n = 0;
    forever begin
      sz = (ACCEL && n >= 8) ? 8 : 4;
      if (dir < 0) nx = (x < sz) ? 0 : x - sz;
      else         nx = (x + sz > MAX_X) ? MAX_X : x + sz;
      if (nx == x) break;
      exp_x_q.push_back(10'(nx));
      x = nx;
      n++;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (paddle_x !== prev_x) begin
        if (exp_x_q.size() == 0) unexpected("paddle_x", int'(paddle_x));
        else check("paddle_x", int'(paddle_x), int'(exp_x_q.pop_front()));
        prev_x <= paddle_x;
      end
      if ({move_l, move_r} !== prev_dir) begin
        if (exp_dir_q.size() == 0) unexpected("dir_lr", int'({move_l, move_r}));
        else check("dir_lr", int'({move_l, move_r}), int'(exp_dir_q.pop_front()));
        prev_dir <= {move_l, move_r};
      end
      if (launch !== 1'b0) begin
        launch_cnt <= launch_cnt + 1;
        if (exp_launch_q.size() == 0) unexpected("launch_cycle", cyc);
        else check("launch_cycle", cyc, exp_launch_q.pop_front());
      end
    end
  end

  initial begin
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("reset_paddle_x", int'(paddle_x), 280);
    check("reset_move_l", int'(move_l), 0);
    check("reset_move_r", int'(move_r), 0);
    check("reset_launch", int'(launch), 0);
    check("reset_at_edge", int'(at_edge), 0);
    mon_en = 1'b1;

    // left held 12 cycles: three steps
    enable = 1'b1;
    exp_dir_q.push_back(2'b10);
    exp_x_q.push_back(10'd276);
    exp_x_q.push_back(10'd272);
    exp_x_q.push_back(10'd268);
    key(1'b1, 8'h61);
    idle(11);
    exp_dir_q.push_back(2'b00);
    key(1'b0, 8'h61);
    idle(4);
    check("frozen_after_break", int'(paddle_x), 268);

    // last-pressed-wins: LEFT, RIGHT, LEFT, IDLE
    exp_dir_q.push_back(2'b10);
    exp_dir_q.push_back(2'b01);
    exp_dir_q.push_back(2'b10);
    exp_dir_q.push_back(2'b00);
    exp_x_q.push_back(10'd264);
    exp_x_q.push_back(10'd268);
    exp_x_q.push_back(10'd264);
    key(1'b1, 8'h61);
    key(1'b1, 8'h6A);
    key(1'b0, 8'h6A);
    key(1'b0, 8'h61);
    idle(20);
    check("frozen_idle", int'(paddle_x), 264);

    // hold into left wall
    exp_dir_q.push_back(2'b10);
    push_run(264, -1);
    key(1'b1, 8'h61);
    idle(300);
    check("left_wall_x", int'(paddle_x), 0);
    check("left_wall_edge", int'(at_edge), 1);
    exp_dir_q.push_back(2'b00);
    key(1'b0, 8'h61);

    // hold into right wall
    exp_dir_q.push_back(2'b01);
    push_run(0, 1);
    key(1'b1, 8'h6A);
    idle(600);
    check("right_wall_x", int'(paddle_x), MAX_X);
    check("right_wall_edge", int'(at_edge), 1);
    check("right_held_move_r", int'(move_r), 1);
    exp_dir_q.push_back(2'b00);
    key(1'b0, 8'h6A);

    // launch: press + repeats fire once, release + press fires again
    key(1'b1, 8'h29);
    exp_launch_q.push_back(ev);
    key(1'b1, 8'h29);
    key(1'b1, 8'h29);
    key(1'b0, 8'h29);
    key(1'b1, 8'h29);
    exp_launch_q.push_back(ev);
    idle(3);
    key(1'b0, 8'h29);
    enable = 1'b0;
    key(1'b1, 8'h29);
    idle(3);
    key(1'b0, 8'h29);
    idle(3);
    check("launch_pulses", launch_cnt, 2);

    // enable=0 freezes motion while state still follows keys
    exp_dir_q.push_back(2'b10);
    key(1'b1, 8'h61);
    idle(9);
    check("disabled_frozen", int'(paddle_x), MAX_X);
    check("disabled_move_l", int'(move_l), 1);
    exp_x_q.push_back(10'd556);
    enable = 1'b1;
    exp_dir_q.push_back(2'b00);
    key(1'b0, 8'h61);
    idle(3);

    // reset while moving right; held flags must be cleared
    exp_dir_q.push_back(2'b01);
    exp_x_q.push_back(10'd560);
    key(1'b1, 8'h6A);
    idle(5);
    exp_x_q.push_back(10'd280);
    exp_dir_q.push_back(2'b00);
    reset = 1'b1;
    idle(1);
    check("midreset_x", int'(paddle_x), 280);
    check("midreset_move_r", int'(move_r), 0);
    reset = 1'b0;
    idle(8);
    exp_dir_q.push_back(2'b10);
    exp_x_q.push_back(10'd276);
    exp_dir_q.push_back(2'b00);
    key(1'b1, 8'h61);
    key(1'b0, 8'h61);
    idle(6);

    check("exp_x_q_drained", exp_x_q.size(), 0);
    check("exp_dir_q_drained", exp_dir_q.size(), 0);
    check("exp_launch_q_drained", exp_launch_q.size(), 0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
